traffic_phase_ctrl: RTL and testbench

- Traffic-light phase sequencer for one two-way intersection (main road and side road). It sits directly downstream of the second counter.
- Consumes the counter's one-cycle `last` pulse as a 1-second tick and drives the counter's `en`.
- Steps through the green / yellow / all-red phases with per-phase durations in seconds. Drives the lamp outputs and a remaining-seconds value for the countdown display.

---
 rtl/traffic_phase_ctrl.sv | 145 ++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: two-way intersection phase sequencer, `define PED_REQ_EN adds pedestrian green truncation
module traffic_phase_ctrl #(
    parameter int pGREEN_SEC     = 25,
    parameter int pYELLOW_SEC    = 3,
    parameter int pALLRED_SEC    = 2,
    parameter int pPED_SHORT_SEC = 5,
    localparam int MAX_SEC = (pGREEN_SEC > pYELLOW_SEC)
                           ? ((pGREEN_SEC > pALLRED_SEC) ? pGREEN_SEC : pALLRED_SEC)
                           : ((pYELLOW_SEC > pALLRED_SEC) ? pYELLOW_SEC : pALLRED_SEC),
    localparam int TW = $clog2(MAX_SEC + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          flash_req,
    input  logic          sec_tick,
`ifdef PED_REQ_EN
    input  logic          ped_req,
`endif
    output logic          cnt_en,
    output logic [2:0]    main_lamp,
    output logic [2:0]    side_lamp,
    output logic [TW-1:0] remaining,
    output logic          phase_done
);
    typedef enum logic [2:0] {
        AR_TO_MAIN = 3'd0,
        MAIN_G     = 3'd1,
        MAIN_Y     = 3'd2,
        AR_TO_SIDE = 3'd3,
        SIDE_G     = 3'd4,
        SIDE_Y     = 3'd5,
        FLASH      = 3'd6
    } state_t;

    localparam logic [TW-1:0] G_L   = TW'(pGREEN_SEC);
    localparam logic [TW-1:0] Y_L   = TW'(pYELLOW_SEC);
    localparam logic [TW-1:0] A_L   = TW'(pALLRED_SEC);
    localparam logic [TW-1:0] ONE   = TW'(1);

    if (pGREEN_SEC < 1 || pYELLOW_SEC < 1 || pALLRED_SEC < 1 || pPED_SHORT_SEC < 1) begin : g_bad_param
        $error("traffic_phase_ctrl: all durations must be >= 1");
    end

    state_t        state_q, state_d, nxt;
    logic [TW-1:0] rem_q, rem_d, nxt_len;
    logic          flash_q, flash_d;
    logic          done_q, done_d;
    logic          cnt_en_q, cnt_en_d;
    logic [2:0]    main_q, main_d, side_q, side_d;
    logic          tick, bad, trunc;
`ifdef PED_REQ_EN
    localparam logic [TW-1:0] PED_L = TW'(pPED_SHORT_SEC);
    logic          ped_q, ped_d;
`endif

    always_comb begin
        tick     = run & sec_tick;
        cnt_en_d = run;
        state_d  = state_q;
        rem_d    = rem_q;
        flash_d  = flash_q;
        done_d   = 1'b0;
        bad      = 1'b0;
        nxt      = AR_TO_MAIN;
        nxt_len  = A_L;
        case (state_q)
            AR_TO_MAIN: begin nxt = MAIN_G;     nxt_len = G_L; end
            MAIN_G:     begin nxt = MAIN_Y;     nxt_len = Y_L; end
            MAIN_Y:     nxt = AR_TO_SIDE;
            AR_TO_SIDE: begin nxt = SIDE_G;     nxt_len = G_L; end
            SIDE_G:     begin nxt = SIDE_Y;     nxt_len = Y_L; end
            SIDE_Y, FLASH: ;
            default:    bad = 1'b1;
        endcase
`ifdef PED_REQ_EN
        trunc = run && ped_q && state_q == MAIN_G && 32'(rem_q) > pPED_SHORT_SEC;
`else
        trunc = 1'b0;
`endif
        // flash entry/exit outranks any expiring tick on the same edge
        if (flash_req != (state_q == FLASH)) begin
            state_d = flash_req ? FLASH : AR_TO_MAIN;
            rem_d   = flash_req ? '0 : A_L;
            flash_d = flash_req;
            done_d  = 1'b1;
        end else if (state_q == FLASH) begin
            flash_d = flash_q ^ tick;
        end else if (bad) begin
            state_d = AR_TO_MAIN;
            rem_d   = A_L;
        end else if (tick && rem_q <= ONE) begin
            state_d = nxt;
            rem_d   = nxt_len;
            done_d  = 1'b1;
        end else if (trunc) begin
`ifdef PED_REQ_EN
            rem_d   = PED_L;
`endif
        end else if (tick) begin
            rem_d   = rem_q - ONE;
        end
`ifdef PED_REQ_EN
        ped_d = (ped_q | ped_req)
              & ~(state_d == FLASH && state_q != FLASH)
              & ~(state_d == SIDE_G && state_q != SIDE_G);
`endif
        main_d = state_d == MAIN_G ? 3'b001 : state_d == MAIN_Y ? 3'b010
               : state_d == FLASH ? {1'b0, flash_d, 1'b0} : 3'b100;
        side_d = state_d == SIDE_G ? 3'b001 : state_d == SIDE_Y ? 3'b010
               : state_d == FLASH ? {1'b0, flash_d, 1'b0} : 3'b100;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= AR_TO_MAIN;
            rem_q    <= A_L;
            flash_q  <= 1'b0;
            done_q   <= 1'b0;
            cnt_en_q <= 1'b0;
            main_q   <= 3'b100;
            side_q   <= 3'b100;
`ifdef PED_REQ_EN
            ped_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            flash_q  <= flash_d;
            done_q   <= done_d;
            cnt_en_q <= cnt_en_d;
            main_q   <= main_d;
            side_q   <= side_d;
`ifdef PED_REQ_EN
            ped_q    <= ped_d;
`endif
        end
    end

    assign cnt_en     = cnt_en_q;
    assign main_lamp  = main_q;
    assign side_lamp  = side_q;
    assign remaining  = rem_q;
    assign phase_done = done_q;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: vector table, directed corner sequences and random run against a phase-table model
`timescale 1ns/1ps
module tb_traffic_phase_ctrl;
`ifdef PED_REQ_EN
    localparam int G = 10;
`else
    localparam int G = 4;
`endif
    localparam int Y  = 2;
    localparam int A  = 1;
    localparam int PS = 5;
    localparam int TW = $clog2(G + 1);

    logic          clk, rst_n, run, flash_req, sec_tick, ped_req;
    logic          cnt_en, phase_done;
    logic [2:0]    main_lamp, side_lamp;
    logic [TW-1:0] remaining;

    traffic_phase_ctrl #(
        .pGREEN_SEC(G), .pYELLOW_SEC(Y), .pALLRED_SEC(A), .pPED_SHORT_SEC(PS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .run(run),
        .flash_req(flash_req),
        .sec_tick(sec_tick),
`ifdef PED_REQ_EN
        .ped_req(ped_req),
`endif
        .cnt_en(cnt_en),
        .main_lamp(main_lamp),
        .side_lamp(side_lamp),
        .remaining(remaining),
        .phase_done(phase_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // model: phase index 0..5 walks the normal ring, 6 is flashing
    int         m_ph, m_rem;
    bit         m_fl, m_done, m_cnt, m_ped;
    int         dur [6]      = '{A, G, Y, A, G, Y};
    logic [2:0] main_tab [6] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
    logic [2:0] side_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010};

    function automatic logic [2:0] exp_main();
        return m_ph == 6 ? (m_fl ? 3'b010 : 3'b000) : main_tab[m_ph];
    endfunction

    function automatic logic [2:0] exp_side();
        return m_ph == 6 ? (m_fl ? 3'b010 : 3'b000) : side_tab[m_ph];
    endfunction

    function automatic void model_reset();
        m_ph = 0; m_rem = A; m_fl = 0; m_done = 0; m_cnt = 0; m_ped = 0;
    endfunction

    function automatic void model_step(bit r, bit f, bit t, bit p);
        bit tk, old_ped;
        tk      = r && t;
        old_ped = m_ped;
        m_done  = 0;
        m_cnt   = r;
        m_ped   = m_ped | p;
        if (m_ph == 6) begin
            if (!f) begin m_ph = 0; m_rem = A; m_fl = 0; m_done = 1; end
            else if (tk) m_fl = !m_fl;
        end else if (f) begin
            m_ph = 6; m_rem = 0; m_fl = 1; m_done = 1; m_ped = 0;
        end else if (tk && m_rem <= 1) begin
            m_ph = (m_ph + 1) % 6; m_rem = dur[m_ph]; m_done = 1;
            if (m_ph == 4) m_ped = 0;
        end else if (r && old_ped && m_ph == 1 && m_rem > PS) begin
            m_rem = PS;
        end else if (tk) begin
            m_rem = m_rem - 1;
        end
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all(string tag);
        chk({tag, ".remaining"}, 32'(remaining), 32'(m_rem));
        chk({tag, ".main_lamp"}, 32'(main_lamp), 32'(exp_main()));
        chk({tag, ".side_lamp"}, 32'(side_lamp), 32'(exp_side()));
        chk({tag, ".phase_done"}, 32'(phase_done), 32'(m_done));
        chk({tag, ".cnt_en"}, 32'(cnt_en), 32'(m_cnt));
    endtask

    task automatic cyc(string tag);
        @(posedge clk);
        model_step(run, flash_req, sec_tick, ped_req);
        #1;
        cmp_all(tag);
    endtask

    task automatic tick1(string tag);
        sec_tick = 1'b1;
        cyc(tag);
        sec_tick = 1'b0;
        repeat (9) cyc(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; flash_req = 1'b0; sec_tick = 1'b0; ped_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.remaining", 32'(remaining), 32'(A));
        chk("reset.main_lamp", 32'(main_lamp), 32'(3'b100));
        chk("reset.side_lamp", 32'(side_lamp), 32'(3'b100));
        chk("reset.cnt_en", 32'(cnt_en), 32'd0);
        chk("reset.phase_done", 32'(phase_done), 32'd0);
        rst_n = 1'b1;
        run   = 1'b1;
    endtask

    typedef struct {
        logic       r, f, t;
        int         rem;
        logic [2:0] mn, sd;
        logic       d, cn;
    } vec_t;
    vec_t vt [12];

    int pulses;
    bit fl_rand;

    initial begin
        vt[0]  = '{1, 0, 1, G,     3'b001, 3'b100, 1, 1};
        vt[1]  = '{1, 0, 1, G - 1, 3'b001, 3'b100, 0, 1};
        vt[2]  = '{0, 0, 1, G - 1, 3'b001, 3'b100, 0, 0};
        vt[3]  = '{1, 0, 0, G - 1, 3'b001, 3'b100, 0, 1};
        vt[4]  = '{1, 1, 0, 0,     3'b010, 3'b010, 1, 1};
        vt[5]  = '{1, 1, 1, 0,     3'b000, 3'b000, 0, 1};
        vt[6]  = '{0, 1, 1, 0,     3'b000, 3'b000, 0, 0};
        vt[7]  = '{1, 1, 1, 0,     3'b010, 3'b010, 0, 1};
        vt[8]  = '{1, 0, 0, A,     3'b100, 3'b100, 1, 1};
        vt[9]  = '{1, 0, 1, G,     3'b001, 3'b100, 1, 1};
        vt[10] = '{1, 1, 1, 0,     3'b010, 3'b010, 1, 1};
        vt[11] = '{1, 0, 0, A,     3'b100, 3'b100, 1, 1};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            run = vt[i].r; flash_req = vt[i].f; sec_tick = vt[i].t;
            cyc("vec");
            chk($sformatf("vec%0d.remaining", i), 32'(remaining), 32'(vt[i].rem));
            chk($sformatf("vec%0d.main_lamp", i), 32'(main_lamp), 32'(vt[i].mn));
            chk($sformatf("vec%0d.side_lamp", i), 32'(side_lamp), 32'(vt[i].sd));
            chk($sformatf("vec%0d.phase_done", i), 32'(phase_done), 32'(vt[i].d));
            chk($sformatf("vec%0d.cnt_en", i), 32'(cnt_en), 32'(vt[i].cn));
        end
        flash_req = 1'b0; sec_tick = 1'b0; run = 1'b1;

        // one full ring from reset: six transitions, back in all-red
        do_reset();
        pulses = 0;
        for (int k = 0; k < 2 * (A + G + Y); k++) begin
            sec_tick = 1'b1;
            cyc("ring");
            pulses += int'(phase_done);
            sec_tick = 1'b0;
            for (int j = 0; j < 9; j++) begin
                cyc("ring");
                pulses += int'(phase_done);
            end
        end
        chk("ring.pulses", 32'(pulses), 32'd6);
        chk("ring.end_remaining", 32'(remaining), 32'(A));
        chk("ring.end_main", 32'(main_lamp), 32'(3'b100));

        // run dropped mid green
        do_reset();
        tick1("rundrop");
        tick1("rundrop");
        run = 1'b0;
        cyc("rundrop");
        chk("rundrop.cnt_en_low", 32'(cnt_en), 32'd0);
        repeat (5) tick1("rundrop");
        chk("rundrop.hold", 32'(remaining), 32'(G - 1));
        run = 1'b1;
        cyc("rundrop");
        chk("rundrop.cnt_en_high", 32'(cnt_en), 32'd1);
        sec_tick = 1'b1;
        cyc("rundrop");
        sec_tick = 1'b0;
        chk("rundrop.resume", 32'(remaining), 32'(G - 2));

        // flash request on the expiring side-green tick
        do_reset();
        for (int i = 0; i < 100 && !(m_ph == 4 && m_rem == 1); i++) tick1("flash");
        chk("flash.reach_side_g_last", 32'(m_ph == 4 && m_rem == 1), 32'd1);
        flash_req = 1'b1; sec_tick = 1'b1;
        cyc("flash");
        sec_tick = 1'b0;
        chk("flash.enter_main", 32'(main_lamp), 32'(3'b010));
        chk("flash.enter_side", 32'(side_lamp), 32'(3'b010));
        chk("flash.enter_rem", 32'(remaining), 32'd0);
        tick1("flash");
        chk("flash.toggle_main", 32'(main_lamp), 32'(3'b000));
        chk("flash.toggle_side", 32'(side_lamp), 32'(3'b000));
        flash_req = 1'b0;
        cyc("flash");
        chk("flash.exit_rem", 32'(remaining), 32'(A));
        chk("flash.exit_main", 32'(main_lamp), 32'(3'b100));

        // asynchronous reset between edges while main yellow
        do_reset();
        for (int i = 0; i < 100 && m_ph != 2; i++) tick1("areset");
        chk("areset.reach_main_y", 32'(m_ph), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("areset.main_lamp", 32'(main_lamp), 32'(3'b100));
        chk("areset.side_lamp", 32'(side_lamp), 32'(3'b100));
        chk("areset.remaining", 32'(remaining), 32'(A));
        chk("areset.cnt_en", 32'(cnt_en), 32'd0);
        model_reset();
        #2 rst_n = 1'b1;
        repeat (3) cyc("areset");

`ifdef PED_REQ_EN
        do_reset();
        tick1("ped");
        tick1("ped");
        ped_req = 1'b1;
        cyc("ped");
        ped_req = 1'b0;
        chk("ped.latch_no_change", 32'(remaining), 32'(G - 1));
        cyc("ped");
        chk("ped.truncate", 32'(remaining), 32'(PS));
        chk("ped.no_done", 32'(phase_done), 32'd0);
        tick1("ped");
        chk("ped.count", 32'(remaining), 32'(PS - 1));
        for (int i = 0; i < 10 && m_rem != 3; i++) tick1("ped");
        ped_req = 1'b1;
        cyc("ped");
        ped_req = 1'b0;
        cyc("ped");
        chk("ped.late_no_change", 32'(remaining), 32'd3);
        for (int i = 0; i < 100 && m_ph != 4; i++) tick1("ped");
        ped_req = 1'b1;
        cyc("ped");
        ped_req = 1'b0;
        for (int i = 0; i < 100 && m_ph != 1; i++) begin
            sec_tick = 1'b1;
            cyc("ped");
            sec_tick = 1'b0;
            if (m_ph != 1) repeat (9) cyc("ped");
        end
        chk("ped.pending_entry", 32'(remaining), 32'(G));
        cyc("ped");
        chk("ped.pending_applied", 32'(remaining), 32'(PS));
`endif

        // random traffic against the model
        do_reset();
        fl_rand = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) fl_rand = ~fl_rand;
            run       = $urandom_range(0, 9) != 0;
            sec_tick  = $urandom_range(0, 3) == 0;
            flash_req = fl_rand;
`ifdef PED_REQ_EN
            ped_req   = $urandom_range(0, 29) == 0;
`endif
            cyc("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
